// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage. Owns the fetch PC, issues word fetches to
// instruction memory over a req/ready handshake and drives the IF/ID
// pipeline register consumed by decode. A decode freeze holds IF/ID. A word
// that returns while frozen is parked in a one-entry hold buffer. An execute
// redirect flushes IF/ID and reloads the PC. If a fetch is still in flight
// when the redirect arrives, that fetch is drained first.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   freeze        in   hold IF/ID (decode hazard)
//   branch_taken  in   redirect request from execute
//   branch_addr   in   redirect target (word aligned)
//   imem_req      out  fetch request
//   imem_addr     out  fetch address, stable while a request waits
//   imem_ready    in   fetch completes this cycle when imem_req=1
//   imem_rdata    in   fetched word, valid with imem_req & imem_ready
//   PC_out        out  IF/ID fetch address + 4
//   Instruction   out  IF/ID instruction
//   valid         out  IF/ID holds a real fetched instruction
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction,
    output logic        valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    logic        acc;
    logic [31:0] pc_plus4;

    // The request stays up in FETCH and DRAIN. In DRAIN, the address is still
    // the address of the abandoned fetch, so the memory sees a stable request.
    assign imem_req  = (state_q != HOLD);
    assign imem_addr = fetch_pc_q;
    assign acc       = imem_req & imem_ready;
    assign pc_plus4  = fetch_pc_q + 32'd4;   // wraps modulo 2^32

    assign Instruction = instr_q;
    assign PC_out      = pc_out_q;
    assign valid       = valid_q;

    always_comb begin
        // NOTE: every signal gets a hold-value default first so that no path
        // leaves it unassigned, which would infer a latch.
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        target_d     = target_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;

        if (branch_taken) begin
            // A redirect flushes IF/ID even while decode is frozen.
            instr_d      = NOP_INSTR;
            valid_d      = 1'b0;
            hold_instr_d = '0;
            hold_pc_d    = '0;
            if (imem_req && !acc) begin
                // The memory still owes a word. Let it return before
                // redirecting, and remember where to go.
                target_d = branch_addr;
                state_d  = DRAIN;
            end else begin
                fetch_pc_d = branch_addr;
                state_d    = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (acc) begin
                        fetch_pc_d = pc_plus4;
                        if (freeze) begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = pc_plus4;
                            state_d      = HOLD;
                        end else begin
                            instr_d  = imem_rdata;
                            pc_out_d = pc_plus4;
                            valid_d  = 1'b1;
                        end
                    end else if (!freeze) begin
                        // Wait state: insert a bubble so that a stale valid
                        // word is not re-issued to decode.
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        instr_d  = hold_instr_q;
                        pc_out_d = hold_pc_q;
                        valid_d  = 1'b1;
                        state_d  = FETCH;
                    end
                end
                DRAIN: begin
                    if (acc) begin
                        fetch_pc_d = target_q;
                        state_d    = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every flop
        // samples the values from before the edge, whatever the statement order.
        if (rst) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            target_q     <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            instr_q      <= NOP_INSTR;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            target_q     <= target_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Bench for if_fetch_stage. Two instances share one stimulus stream: one
// resets to 0 and the other to 0xFFFF_FFFC, which exercises PC wrap. Each
// instance's memory is a ROM with mem[i] = i + 0x100. The ROM is modelled
// by an address function, and the shared imem_ready line sets the wait
// states. A reference model tracks the fetch stream: where fetching
// continues, whether a word is parked, whether a redirect is pending, and
// what decode should see.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_ready;

    logic        req_w   [2];
    logic [31:0] addr_w  [2];
    logic [31:0] rdata_w [2];
    logic [31:0] pcout_w [2];
    logic [31:0] instr_w [2];
    logic        valid_w [2];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]} + 32'h100;
    endfunction

    assign rdata_w[0] = mem_word(addr_w[0]);
    assign rdata_w[1] = mem_word(addr_w[1]);

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(req_w[0]), .imem_addr(addr_w[0]),
        .imem_ready(imem_ready), .imem_rdata(rdata_w[0]),
        .PC_out(pcout_w[0]), .Instruction(instr_w[0]), .valid(valid_w[0])
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(req_w[1]), .imem_addr(addr_w[1]),
        .imem_ready(imem_ready), .imem_rdata(rdata_w[1]),
        .PC_out(pcout_w[1]), .Instruction(instr_w[1]), .valid(valid_w[1])
    );

    // Reference view of one fetch unit.
    typedef struct packed {
        logic [31:0] pc;          // next address to fetch (or in flight)
        logic [31:0] target;      // pending redirect after a drain
        logic [31:0] ifid_instr;
        logic [31:0] ifid_pc;
        logic [31:0] buf_instr;
        logic [31:0] buf_pc;
        logic        ifid_valid;
        logic        has_buf;     // a word is parked; no request out
        logic        drain;       // a stale fetch must finish before redirect
    } model_t;

    model_t      m [2];
    logic [31:0] reset_pc [2];
    logic        known = 1'b0;

    function automatic model_t model_next(
        input model_t      cur,
        input logic [31:0] rpc,
        input logic        r,
        input logic        b,
        input logic [31:0] ba,
        input logic        f,
        input logic        rdy
    );
        model_t n;
        logic req, got;
        n   = cur;
        req = !cur.has_buf;
        got = req && rdy;
        if (r) begin
            n = '0;
            n.pc = rpc;
            n.ifid_instr = NOP;
        end else if (b) begin
            n.ifid_instr = NOP;
            n.ifid_valid = 1'b0;
            n.has_buf    = 1'b0;
            if (req && !got) begin
                n.drain  = 1'b1;
                n.target = ba;
            end else begin
                n.pc    = ba;
                n.drain = 1'b0;
            end
        end else if (cur.has_buf) begin
            if (!f) begin
                n.ifid_instr = cur.buf_instr;
                n.ifid_pc    = cur.buf_pc;
                n.ifid_valid = 1'b1;
                n.has_buf    = 1'b0;
            end
        end else if (cur.drain) begin
            if (got) begin
                n.pc    = cur.target;
                n.drain = 1'b0;
            end
        end else if (got) begin
            n.pc = cur.pc + 32'd4;
            if (f) begin
                n.has_buf   = 1'b1;
                n.buf_instr = mem_word(cur.pc);
                n.buf_pc    = cur.pc + 32'd4;
            end else begin
                n.ifid_instr = mem_word(cur.pc);
                n.ifid_pc    = cur.pc + 32'd4;
                n.ifid_valid = 1'b1;
            end
        end else if (!f) begin
            n.ifid_instr = NOP;
            n.ifid_valid = 1'b0;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Drive the inputs, check the request outputs before
    // the edge, advance the model, then check IF/ID just after the edge.
    task automatic cycle(input logic r, input logic b, input logic [31:0] ba,
                         input logic f, input logic rdy);
        rst = r; branch_taken = b; branch_addr = ba; freeze = f; imem_ready = rdy;
        #1;
        if (known) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("d%0d.imem_req", i), {31'b0, req_w[i]}, {31'b0, !m[i].has_buf});
                if (!m[i].has_buf)
                    check($sformatf("d%0d.imem_addr", i), addr_w[i], m[i].pc);
            end
        end
        for (int i = 0; i < 2; i++)
            m[i] = model_next(m[i], reset_pc[i], r, b, ba, f, rdy);
        if (r) known = 1'b1;
        @(posedge clk);
        #1;
        if (known) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("d%0d.Instruction", i), instr_w[i], m[i].ifid_instr);
                check($sformatf("d%0d.PC_out", i), pcout_w[i], m[i].ifid_pc);
                check($sformatf("d%0d.valid", i), {31'b0, valid_w[i]}, {31'b0, m[i].ifid_valid});
            end
        end
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
    endtask

    initial begin
        reset_pc[0] = 32'h0000_0000;
        reset_pc[1] = 32'hFFFF_FFFC;
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
        branch_addr = '0; imem_ready = 1'b1;

        // Reset values and zero-wait boot stream.
        do_reset();
        check("rst.instr", instr_w[0], NOP);
        check("rst.valid", {31'b0, valid_w[0]}, 32'd0);
        check("rst.addr1", addr_w[1], 32'hFFFF_FFFC);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 1);
            check("boot.instr", instr_w[0], 32'h100 + k);
            check("boot.pc", pcout_w[0], 32'd4 * (k + 1));
            check("boot.valid", {31'b0, valid_w[0]}, 32'd1);
            if (k == 0) begin
                check("wrap.pc_out", pcout_w[1], 32'h0);
                check("wrap.instr", instr_w[1], 32'h4000_00FF);
            end
        end

        // Freeze for three cycles while word 2 returns.
        do_reset();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, 1);
            check("frz.instr", instr_w[0], 32'h101);
            check("frz.req", {31'b0, req_w[0]}, 32'd0);
        end
        cycle(0, 0, 0, 0, 1);
        check("rel.instr", instr_w[0], 32'h102);
        check("rel.pc", pcout_w[0], 32'hC);
        cycle(0, 0, 0, 0, 1);
        check("rel.next", instr_w[0], 32'h103);

        // Two-wait memory.
        do_reset();
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 2; k++) begin
                cycle(0, 0, 0, 0, 0);
                check("wait.valid", {31'b0, valid_w[0]}, 32'd0);
                check("wait.addr", addr_w[0], 32'd4 * w);
            end
            cycle(0, 0, 0, 0, 1);
            check("wait.instr", instr_w[0], 32'h100 + w);
        end

        // Branch during the wait of fetch 0x8.
        do_reset();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 32'h40, 0, 0);
        check("br.flush", instr_w[0], NOP);
        check("br.pc_keep", pcout_w[0], 32'h8);
        check("br.drain_addr", addr_w[0], 32'h8);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check("br.drop", {31'b0, valid_w[0]}, 32'd0);
        check("br.new_addr", addr_w[0], 32'h40);
        cycle(0, 0, 0, 0, 1);
        check("br.instr", instr_w[0], 32'h110);
        check("br.pc", pcout_w[0], 32'h44);

        // Branch together with freeze while in HOLD.
        cycle(0, 0, 0, 1, 1);
        cycle(0, 1, 32'h80, 1, 1);
        check("hbr.valid", {31'b0, valid_w[0]}, 32'd0);
        check("hbr.req", {31'b0, req_w[0]}, 32'd1);
        check("hbr.addr", addr_w[0], 32'h80);
        cycle(0, 0, 0, 0, 1);
        check("hbr.instr", instr_w[0], 32'h120);

        // Reset in the middle of a wait.
        do_reset();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("mrst.addr1", addr_w[1], 32'hFFFF_FFFC);
        check("mrst.addr0", addr_w[0], 32'h0);

        // Randomized traffic checked against the model.
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 7) == 0,
                  {$urandom, 2'b00} >> 2 << 2,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
